// File: rtl/buf2wdma_if.sv
// Bundle of the buffer-read port, the DRAM write command/data channels and the
// transfer control/status signals of buf2wdma.
interface buf2wdma_if #(
    parameter int unsigned TOUT         = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned LOG2_BURST   = 4,
    parameter int unsigned LOG2_W       = 8,
    parameter int unsigned LOG2_H       = 8,
    parameter int unsigned LOG2_CH      = 10,
    parameter int unsigned LOG2_BUF_DEP = 14
);
    logic                       start;
    logic [LOG2_W-1:0]          Wout;
    logic [LOG2_H-1:0]          Hout;
    logic [LOG2_CH-1:0]         CH_out_div_Tout;
    logic [LOG2_W+LOG2_H-1:0]   Hout_x_Wout;
    logic [31:0]                base_addr;
    logic [LOG2_H:0]            rows_ready;

    logic                       buf_rd_en;
    logic [LOG2_BUF_DEP-1:0]    buf_rd_addr;
    logic [TOUT*DW-1:0]         buf_rd_data;

    logic                       wr_cmd_vld;
    logic                       wr_cmd_rdy;
    logic [31:0]                wr_cmd_addr;
    logic [LOG2_BURST-1:0]      wr_cmd_len;

    logic                       wr_dat_vld;
    logic                       wr_dat_rdy;
    logic [TOUT*DW-1:0]         wr_dat_pd;
    logic                       wr_dat_last;

    logic                       busy;
    logic                       dma_wdat_done;

    modport master (
        input  start, Wout, Hout, CH_out_div_Tout, Hout_x_Wout, base_addr, rows_ready,
        input  buf_rd_data, wr_cmd_rdy, wr_dat_rdy,
        output buf_rd_en, buf_rd_addr,
        output wr_cmd_vld, wr_cmd_addr, wr_cmd_len,
        output wr_dat_vld, wr_dat_pd, wr_dat_last,
        output busy, dma_wdat_done
    );

    modport slave (
        output start, Wout, Hout, CH_out_div_Tout, Hout_x_Wout, base_addr, rows_ready,
        output buf_rd_data, wr_cmd_rdy, wr_dat_rdy,
        input  buf_rd_en, buf_rd_addr,
        input  wr_cmd_vld, wr_cmd_addr, wr_cmd_len,
        input  wr_dat_vld, wr_dat_pd, wr_dat_last,
        input  busy, dma_wdat_done
    );
endinterface

// File: rtl/buf2wdma.sv
// Streams output rows from the on-chip buffer to DRAM as write bursts, walking
// burst-in-row, then output channel, then output row.
module buf2wdma #(
    parameter int unsigned TOUT         = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned LOG2_BURST   = 4,
    parameter int unsigned LOG2_W       = 8,
    parameter int unsigned LOG2_H       = 8,
    parameter int unsigned LOG2_CH      = 10,
    parameter int unsigned LOG2_BUF_DEP = 14
) (
    input logic        clk,
    input logic        rst_n,
    buf2wdma_if.master bus
);
    localparam int unsigned DATW  = TOUT * DW;
    localparam int unsigned HWW   = LOG2_W + LOG2_H;
    localparam int unsigned IDXW  = LOG2_CH + HWW;
    localparam int unsigned BYTES = DATW / 8;

    typedef enum logic [2:0] {IDLE, WAIT_ROW, CMD, RDBUF, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [LOG2_W-1:0]     k_q, k_d;
    logic [LOG2_W-1:0]     kb_q, kb_d;
    logic [LOG2_CH-1:0]    ch_q, ch_d;
    logic [IDXW-1:0]       cb_q, cb_d;
    logic [LOG2_H-1:0]     h_q, h_d;
    logic [HWW-1:0]        hb_q, hb_d;
    logic [LOG2_BURST-1:0] beat_q, beat_d;
    logic                  zdone_q, zdone_d;

    logic [1:0]            rdv_q;
    logic [1:0]            rdl_q;
    logic [DATW-1:0]       fdat_q [4];
    logic [3:0]            flast_q;
    logic [1:0]            wp_q, rp_q;
    logic [2:0]            cnt_q;

    logic [LOG2_W-1:0]     wm1, kmax;
    logic [LOG2_BURST-1:0] cur_len;
    logic                  last_k, last_ch, last_h, last_beat, zero_dims;
    logic [IDXW-1:0]       idx0, idx;
    logic [31:0]           idx0_32;
    logic [3:0]            occupancy;
    logic                  rd_fire, push, pop, final_pop;

    always_comb begin
        wm1       = bus.Wout - LOG2_W'(1);
        kmax      = wm1 >> LOG2_BURST;
        last_k    = (k_q == kmax);
        cur_len   = last_k ? wm1[LOG2_BURST-1:0] : '1;
        last_beat = (beat_q == cur_len);
        last_ch   = (ch_q == bus.CH_out_div_Tout - LOG2_CH'(1));
        last_h    = (h_q == bus.Hout - LOG2_H'(1));
        zero_dims = (bus.Wout == '0) || (bus.Hout == '0) || (bus.CH_out_div_Tout == '0);
        idx0      = cb_q + IDXW'(hb_q) + IDXW'(kb_q);
        idx       = idx0 + IDXW'(beat_q);
        idx0_32   = 32'(idx0);
        // Reads already issued but not yet in the FIFO still own a FIFO slot.
        occupancy = 4'(cnt_q) + 4'(rdv_q[0]) + 4'(rdv_q[1]);
        rd_fire   = (state_q == RDBUF) && (occupancy < 4'd4);
        push      = rdv_q[1];
        pop       = (cnt_q != '0) && bus.wr_dat_rdy;
        final_pop = (state_q == FLUSH) && pop && (cnt_q == 3'd1) && (rdv_q == 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            kb_q    <= '0;
            ch_q    <= '0;
            cb_q    <= '0;
            h_q     <= '0;
            hb_q    <= '0;
            beat_q  <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            kb_q    <= kb_d;
            ch_q    <= ch_d;
            cb_q    <= cb_d;
            h_q     <= h_d;
            hb_q    <= hb_d;
            beat_q  <= beat_d;
            zdone_q <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        kb_d    = kb_q;
        ch_d    = ch_q;
        cb_d    = cb_q;
        h_d     = h_q;
        hb_d    = hb_q;
        beat_d  = beat_q;
        zdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_d    = '0;
                    kb_d   = '0;
                    ch_d   = '0;
                    cb_d   = '0;
                    h_d    = '0;
                    hb_d   = '0;
                    beat_d = '0;
                    if (zero_dims) zdone_d = 1'b1;
                    else           state_d = WAIT_ROW;
                end
            end
            WAIT_ROW: if (bus.rows_ready > {1'b0, h_q}) state_d = CMD;
            CMD:      if (bus.wr_cmd_rdy) state_d = RDBUF;
            RDBUF: begin
                if (rd_fire) begin
                    beat_d = beat_q + LOG2_BURST'(1);
                    if (last_beat) begin
                        // Bias registers track k*2^LOG2_BURST, chout*HxW and hout*Wout.
                        beat_d  = '0;
                        state_d = CMD;
                        if (last_k) begin
                            k_d  = '0;
                            kb_d = '0;
                            if (last_ch) begin
                                ch_d = '0;
                                cb_d = '0;
                                if (last_h) begin
                                    h_d     = '0;
                                    hb_d    = '0;
                                    state_d = FLUSH;
                                end else begin
                                    h_d     = h_q + LOG2_H'(1);
                                    hb_d    = hb_q + HWW'(bus.Wout);
                                    state_d = WAIT_ROW;
                                end
                            end else begin
                                ch_d = ch_q + LOG2_CH'(1);
                                cb_d = cb_q + IDXW'(bus.Hout_x_Wout);
                            end
                        end else begin
                            k_d  = k_q + LOG2_W'(1);
                            kb_d = kb_q + (LOG2_W'(1) << LOG2_BURST);
                        end
                    end
                end
            end
            FLUSH:    if (final_pop) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.buf_rd_en     = rd_fire;
        bus.buf_rd_addr   = rd_fire ? LOG2_BUF_DEP'(idx) : '0;
        bus.wr_cmd_vld    = (state_q == CMD);
        bus.wr_cmd_addr   = (state_q == CMD) ? bus.base_addr + idx0_32 * 32'(BYTES) : '0;
        bus.wr_cmd_len    = (state_q == CMD) ? cur_len : '0;
        bus.wr_dat_vld    = (cnt_q != '0);
        bus.wr_dat_pd     = (cnt_q != '0) ? fdat_q[rp_q] : '0;
        bus.wr_dat_last   = (cnt_q != '0) && flast_q[rp_q];
        bus.busy          = (state_q != IDLE);
        bus.dma_wdat_done = zdone_q | final_pop;
    end

    // Two-stage tag pipe matching the buffer's read latency, then a 4-entry FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdv_q   <= '0;
            rdl_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            flast_q <= '0;
            for (int unsigned i = 0; i < 4; i++) fdat_q[i] <= '0;
        end else begin
            rdv_q <= {rdv_q[0], rd_fire};
            rdl_q <= {rdl_q[0], rd_fire & last_beat};
            if (push) begin
                fdat_q[wp_q]  <= bus.buf_rd_data;
                flast_q[wp_q] <= rdl_q[1];
                wp_q          <= wp_q + 2'd1;
            end
            if (pop) rp_q <= rp_q + 2'd1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_buf2wdma.sv
// Randomized bench for buf2wdma: a loop-level reference model predicts commands,
// buffer reads and data beats, compared against what the monitor records.
module tb_buf2wdma;
    logic clk;
    logic rst_n;

    buf2wdma_if #(.TOUT(8), .DW(8), .LOG2_BURST(4), .LOG2_W(8), .LOG2_H(8),
                  .LOG2_CH(10), .LOG2_BUF_DEP(14)) bus ();

    buf2wdma #(.TOUT(8), .DW(8), .LOG2_BURST(4), .LOG2_W(8), .LOG2_H(8),
               .LOG2_CH(10), .LOG2_BUF_DEP(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] salt;
    logic [35:0] exp_cmd[$], got_cmd[$];
    logic [13:0] exp_rd[$],  got_rd[$];
    logic [64:0] exp_beat[$], got_beat[$];
    int done_cnt, stab_err, max_os, rd_total, pop_total, traffic;
    int rdy_mode, cyc;
    logic stall_d, stall_c;
    logic [64:0] held_d;
    logic [35:0] held_c;
    logic [13:0] mem_a;
    logic [119:0] outs;

    assign outs = {bus.buf_rd_en, bus.buf_rd_addr, bus.wr_cmd_vld, bus.wr_cmd_addr,
                   bus.wr_cmd_len, bus.wr_dat_vld, bus.wr_dat_pd, bus.wr_dat_last,
                   bus.busy, bus.dma_wdat_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mk(input logic [13:0] a);
        logic [31:0] x;
        x = {18'd0, a};
        return {(x * 32'h9E3779B1) ^ salt, x ^ ~salt};
    endfunction

    // Buffer model: data appears two cycles after the read request.
    always @(posedge clk) begin
        mem_a           <= bus.buf_rd_addr;
        bus.buf_rd_data <= mk(mem_a);
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: begin bus.wr_dat_rdy = 1'b1; bus.wr_cmd_rdy = 1'b1; end
                1: begin bus.wr_dat_rdy = (cyc % 3 == 0); bus.wr_cmd_rdy = 1'($urandom_range(0, 1)); end
                default: begin bus.wr_dat_rdy = 1'($urandom_range(0, 1)); bus.wr_cmd_rdy = 1'($urandom_range(0, 1)); end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_d = 1'b0;
            stall_c = 1'b0;
        end else begin
            if (bus.wr_cmd_vld && bus.wr_cmd_rdy) got_cmd.push_back({bus.wr_cmd_addr, bus.wr_cmd_len});
            if (bus.buf_rd_en) begin
                got_rd.push_back(bus.buf_rd_addr);
                rd_total++;
            end
            if (bus.buf_rd_en || bus.wr_cmd_vld) traffic++;
            if (rd_total - pop_total > max_os) max_os = rd_total - pop_total;
            if (stall_d && (!bus.wr_dat_vld || {bus.wr_dat_pd, bus.wr_dat_last} !== held_d)) stab_err++;
            if (stall_c && (!bus.wr_cmd_vld || {bus.wr_cmd_addr, bus.wr_cmd_len} !== held_c)) stab_err++;
            stall_d = bus.wr_dat_vld && !bus.wr_dat_rdy;
            stall_c = bus.wr_cmd_vld && !bus.wr_cmd_rdy;
            held_d  = {bus.wr_dat_pd, bus.wr_dat_last};
            held_c  = {bus.wr_cmd_addr, bus.wr_cmd_len};
            if (bus.wr_dat_vld && bus.wr_dat_rdy) begin
                got_beat.push_back({bus.wr_dat_pd, bus.wr_dat_last});
                pop_total++;
            end
            if (bus.dma_wdat_done) done_cnt++;
        end
    end

    task automatic clear_obs();
        got_cmd.delete(); got_rd.delete(); got_beat.delete();
        done_cnt = 0; stab_err = 0; max_os = 0; rd_total = 0; pop_total = 0; traffic = 0;
    endtask

    task automatic build_model(input int w, input int h, input int c, input logic [31:0] base);
        int kmax, len, i0;
        logic [13:0] a;
        exp_cmd.delete(); exp_rd.delete(); exp_beat.delete();
        kmax = (w - 1) / 16;
        for (int hh = 0; hh < h; hh++)
            for (int cc = 0; cc < c; cc++)
                for (int k = 0; k <= kmax; k++) begin
                    i0  = cc * h * w + hh * w + k * 16;
                    len = (k == kmax) ? (w - 1) % 16 : 15;
                    exp_cmd.push_back({base + 32'(i0) * 32'd8, 4'(len)});
                    for (int b = 0; b <= len; b++) begin
                        a = 14'(i0 + b);
                        exp_rd.push_back(a);
                        exp_beat.push_back({mk(a), b == len});
                    end
                end
    endtask

    task automatic launch(input int w, input int h, input int c, input logic [31:0] base);
        @(posedge clk);
        #1;
        bus.Wout            = 8'(w);
        bus.Hout            = 8'(h);
        bus.CH_out_div_Tout = 10'(c);
        bus.Hout_x_Wout     = 16'(h * w);
        bus.base_addr       = base;
        bus.start           = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > 0 && !bus.busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outs got %h required 0", outs); end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (outs !== '0) begin n_fail++; $display("FAIL idle_outs got %h required 0", outs); end
    endtask

    task automatic test_single();
        bit ok;
        logic [31:0] base;
        base = $urandom; salt = $urandom;
        clear_obs(); rdy_mode = 0; bus.rows_ready = 9'd1;
        build_model(16, 1, 1, base);
        launch(16, 1, 1, base);
        wait_done(500, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout done=%0d required 1", done_cnt); end
        n_chk++; if (got_cmd.size() != 1) begin n_fail++; $display("FAIL single_cmd_count got %0d required 1", got_cmd.size()); end
        n_chk++; if (got_cmd.size() > 0 && got_cmd[0] !== {base, 4'd15}) begin n_fail++; $display("FAIL single_cmd got %h required %h", got_cmd[0], {base, 4'd15}); end
        n_chk++; if (got_beat.size() != 16) begin n_fail++; $display("FAIL single_beat_count got %0d required 16", got_beat.size()); end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            n_chk++;
            if (got_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL single_beat[%0d] got %h required %h", i, got_beat[i], exp_beat[i]); end
        end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done got %0d required 1", done_cnt); end
    endtask

    task automatic test_multi();
        bit ok;
        logic [31:0] base;
        base = $urandom; salt = $urandom;
        clear_obs(); rdy_mode = 0; bus.rows_ready = 9'd2;
        build_model(20, 2, 2, base);
        launch(20, 2, 2, base);
        wait_done(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL multi_timeout done=%0d required 1", done_cnt); end
        n_chk++; if (got_cmd.size() != 8) begin n_fail++; $display("FAIL multi_cmd_count got %0d required 8", got_cmd.size()); end
        for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) begin
            n_chk++;
            if (got_cmd[i] !== exp_cmd[i]) begin n_fail++; $display("FAIL multi_cmd[%0d] got %h required %h", i, got_cmd[i], exp_cmd[i]); end
        end
        n_chk++; if (got_rd.size() != 80) begin n_fail++; $display("FAIL multi_rd_count got %0d required 80", got_rd.size()); end
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++) begin
            n_chk++;
            if (got_rd[i] !== exp_rd[i]) begin n_fail++; $display("FAIL multi_rd[%0d] got %0d required %0d", i, got_rd[i], exp_rd[i]); end
        end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            n_chk++;
            if (got_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL multi_beat[%0d] got %h required %h", i, got_beat[i], exp_beat[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] base;
        base = $urandom; salt = $urandom;
        clear_obs(); rdy_mode = 1; bus.rows_ready = 9'd2;
        build_model(37, 2, 2, base);
        launch(37, 2, 2, base);
        wait_done(5000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_timeout done=%0d required 1", done_cnt); end
        n_chk++; if (got_beat.size() != exp_beat.size()) begin n_fail++; $display("FAIL bp_beat_count got %0d required %0d", got_beat.size(), exp_beat.size()); end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            n_chk++;
            if (got_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL bp_beat[%0d] got %h required %h", i, got_beat[i], exp_beat[i]); end
        end
        n_chk++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable changes=%0d required 0", stab_err); end
        n_chk++; if (max_os > 4) begin n_fail++; $display("FAIL bp_outstanding got %0d required <=4", max_os); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done got %0d required 1", done_cnt); end
    endtask

    task automatic test_rows_wait();
        bit ok;
        logic [31:0] base;
        base = $urandom; salt = $urandom;
        clear_obs(); rdy_mode = 0; bus.rows_ready = 9'd0;
        build_model(20, 2, 1, base);
        launch(20, 2, 1, base);
        repeat (50) @(negedge clk);
        n_chk++; if (traffic != 0) begin n_fail++; $display("FAIL rows_traffic got %0d required 0", traffic); end
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rows_busy got %b required 1", bus.busy); end
        @(posedge clk); #1; bus.rows_ready = 9'd2;
        wait_done(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rows_timeout done=%0d required 1", done_cnt); end
        for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) begin
            n_chk++;
            if (got_cmd[i] !== exp_cmd[i]) begin n_fail++; $display("FAIL rows_cmd[%0d] got %h required %h", i, got_cmd[i], exp_cmd[i]); end
        end
        n_chk++; if (got_beat.size() != 40) begin n_fail++; $display("FAIL rows_beat_count got %0d required 40", got_beat.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] base;
        base = $urandom; salt = $urandom;
        clear_obs(); rdy_mode = 1; bus.rows_ready = 9'd1;
        launch(40, 1, 2, base);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); if (got_rd.size() >= 6) ok = 1'b1; end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_reads got %0d required >=6", got_rd.size()); end
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL rmid_outs got %h required 0", outs); end
        repeat (2) @(negedge clk);
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL rmid_outs_hold got %h required 0", outs); end
        @(posedge clk); #1; rst_n = 1'b1;
        clear_obs(); rdy_mode = 0; base = $urandom;
        build_model(20, 1, 1, base);
        launch(20, 1, 1, base);
        wait_done(2000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout done=%0d required 1", done_cnt); end
        for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) begin
            n_chk++;
            if (got_cmd[i] !== exp_cmd[i]) begin n_fail++; $display("FAIL rmid_cmd[%0d] got %h required %h", i, got_cmd[i], exp_cmd[i]); end
        end
        n_chk++; if (got_rd.size() != 20) begin n_fail++; $display("FAIL rmid_rd_count got %0d required 20", got_rd.size()); end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            n_chk++;
            if (got_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL rmid_beat[%0d] got %h required %h", i, got_beat[i], exp_beat[i]); end
        end
    endtask

    task automatic test_zero();
        int w, h, c;
        for (int t = 0; t < 3; t++) begin
            w = (t == 0) ? 0 : 12; h = (t == 1) ? 0 : 2; c = (t == 2) ? 0 : 3;
            clear_obs(); rdy_mode = 0; bus.rows_ready = 9'd2;
            launch(w, h, c, $urandom);
            @(negedge clk);
            n_chk++; if (bus.dma_wdat_done !== 1'b1) begin n_fail++; $display("FAIL zero%0d_done got %b required 1", t, bus.dma_wdat_done); end
            n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero%0d_busy got %b required 0", t, bus.busy); end
            repeat (10) @(negedge clk);
            n_chk++; if (traffic != 0) begin n_fail++; $display("FAIL zero%0d_traffic got %0d required 0", t, traffic); end
            n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero%0d_done_count got %0d required 1", t, done_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] base;
        base = $urandom; salt = $urandom;
        clear_obs(); rdy_mode = 2; bus.rows_ready = 9'd1;
        build_model(17, 1, 2, base);
        launch(17, 1, 2, base);
        repeat (10) @(posedge clk);
        #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        wait_done(3000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout done=%0d required 1", done_cnt); end
        n_chk++; if (got_cmd.size() != exp_cmd.size()) begin n_fail++; $display("FAIL b2b_cmd_count got %0d required %0d", got_cmd.size(), exp_cmd.size()); end
        n_chk++; if (got_beat.size() != exp_beat.size()) begin n_fail++; $display("FAIL b2b_beat_count got %0d required %0d", got_beat.size(), exp_beat.size()); end
        for (int r = 0; r < 4; r++) begin
            int w, h, c;
            w = $urandom_range(1, 40); h = $urandom_range(1, 3); c = $urandom_range(1, 3);
            base = $urandom;
            clear_obs(); bus.rows_ready = 9'd0;
            build_model(w, h, c, base);
            launch(w, h, c, base);
            for (int row = 1; row <= h; row++) begin
                repeat ($urandom_range(0, 30)) @(posedge clk);
                #1; bus.rows_ready = 9'(row);
            end
            wait_done(6000, ok);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_timeout done=%0d required 1", r, done_cnt); end
            n_chk++; if (got_beat.size() != exp_beat.size()) begin n_fail++; $display("FAIL rnd%0d_beat_count got %0d required %0d", r, got_beat.size(), exp_beat.size()); end
            for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) begin
                n_chk++;
                if (got_cmd[i] !== exp_cmd[i]) begin n_fail++; $display("FAIL rnd%0d_cmd[%0d] got %h required %h", r, i, got_cmd[i], exp_cmd[i]); end
            end
            for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
                n_chk++;
                if (got_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL rnd%0d_beat[%0d] got %h required %h", r, i, got_beat[i], exp_beat[i]); end
            end
            n_chk++; if (stab_err != 0 || max_os > 4) begin n_fail++; $display("FAIL rnd%0d_protocol stab=%0d os=%0d required 0/<=4", r, stab_err, max_os); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rdy_mode = 0;
        salt = 32'h1234_5678;
        bus.start = 1'b0;
        bus.Wout = '0;
        bus.Hout = '0;
        bus.CH_out_div_Tout = '0;
        bus.Hout_x_Wout = '0;
        bus.base_addr = '0;
        bus.rows_ready = '0;
        bus.wr_cmd_rdy = 1'b1;
        bus.wr_dat_rdy = 1'b1;
        clear_obs();
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_rows_wait();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
